// File: rtl/scmi_doorbell_scheduler.sv
// Serialises SCMI mailbox doorbells onto one server interrupt with round-robin fairness.
// Optional service watchdog: define SCMI_DOORBELL_SCHED_TIMEOUT_EN.
//
// state    | meaning
// IDLE     | no request outstanding; grants the next eligible channel
// NOTIFY   | srv_irq_o high, waiting for the server to acknowledge
// SERVICE  | acknowledged, waiting for srv_done_i
// COMPLETE | one-cycle completion pulse back to the granted channel
module scmi_doorbell_scheduler #(
  parameter int NumChannels   = 4,
  parameter int TimeoutCycles = 1024,
  parameter int ChanIdWidth   = $clog2(NumChannels)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NumChannels-1:0] doorbell_i,
  input  logic [NumChannels-1:0] chan_en_i,
  output logic                   srv_irq_o,
  output logic [ChanIdWidth-1:0] srv_chan_o,
  input  logic                   srv_ack_i,
  input  logic                   srv_done_i,
  output logic [NumChannels-1:0] completion_o,
  output logic [NumChannels-1:0] pending_o,
  output logic                   busy_o,
  output logic                   timeout_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    NOTIFY   = 2'd1,
    SERVICE  = 2'd2,
    COMPLETE = 2'd3
  } state_t;

  if (NumChannels < 2 || NumChannels > 32 || TimeoutCycles < 2) begin : g_bad_param
    $error("scmi_doorbell_scheduler: illegal parameter value");
  end

  localparam logic [ChanIdWidth-1:0] LastChan = ChanIdWidth'(NumChannels - 1);

  state_t                   r_state;
  logic [ChanIdWidth-1:0]   r_ptr;
  logic [ChanIdWidth-1:0]   r_srv_chan;
  logic [NumChannels-1:0]   r_db_q;
  logic [NumChannels-1:0]   r_pending;
  logic [NumChannels-1:0]   r_completion;
  logic                     r_irq;
  logic                     r_busy;

  logic [NumChannels-1:0]   w_rise;
  logic [NumChannels-1:0]   w_eligible;
  logic [NumChannels-1:0]   w_grant_clr;
  logic [ChanIdWidth-1:0]   w_winner;
  logic                     w_found;
  logic                     w_grant;

  assign w_rise     = doorbell_i & ~r_db_q;
  assign w_eligible = r_pending & chan_en_i;
  assign w_grant    = (r_state == IDLE) && w_found;

  // First eligible index at or after r_ptr, wrapping past the last channel.
  always_comb begin : rr_search
    int j;
    j        = 0;
    w_found  = 1'b0;
    w_winner = '0;
    for (int k = 0; k < NumChannels; k++) begin
      j = int'(r_ptr) + k;
      if (j >= NumChannels) j = j - NumChannels;
      if (!w_found && w_eligible[j]) begin
        w_found  = 1'b1;
        w_winner = ChanIdWidth'(j);
      end
    end
  end

  assign w_grant_clr = w_grant ? (NumChannels'(1) << w_winner) : '0;

  // A new rise on the channel being granted wins over the grant's clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_db_q    <= '0;
      r_pending <= '0;
    end else begin
      r_db_q    <= doorbell_i;
      r_pending <= (r_pending & ~w_grant_clr) | w_rise;
    end
  end

`ifdef SCMI_DOORBELL_SCHED_TIMEOUT_EN
  localparam int CntW = $clog2(TimeoutCycles + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(TimeoutCycles - 1);

  logic [CntW-1:0] r_cnt;
  logic            r_timeout;
  logic            w_limit;

  assign w_limit   = (r_cnt == CntMax);
  assign timeout_o = r_timeout;
`else
  assign timeout_o = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= IDLE;
      r_ptr        <= '0;
      r_srv_chan   <= '0;
      r_completion <= '0;
      r_irq        <= 1'b0;
      r_busy       <= 1'b0;
`ifdef SCMI_DOORBELL_SCHED_TIMEOUT_EN
      r_cnt        <= '0;
      r_timeout    <= 1'b0;
`endif
    end else begin
      r_completion <= '0;
`ifdef SCMI_DOORBELL_SCHED_TIMEOUT_EN
      r_timeout    <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_srv_chan <= w_winner;
            r_ptr      <= (w_winner == LastChan) ? '0 : w_winner + ChanIdWidth'(1);
            r_irq      <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= NOTIFY;
`ifdef SCMI_DOORBELL_SCHED_TIMEOUT_EN
            r_cnt      <= '0;
`endif
          end
        end
        NOTIFY: begin
`ifdef SCMI_DOORBELL_SCHED_TIMEOUT_EN
          r_cnt <= r_cnt + CntW'(1);
`endif
          if (srv_ack_i && srv_done_i) begin
            r_irq        <= 1'b0;
            r_completion <= NumChannels'(1) << r_srv_chan;
            r_state      <= COMPLETE;
`ifdef SCMI_DOORBELL_SCHED_TIMEOUT_EN
          end else if (w_limit) begin
            r_irq        <= 1'b0;
            r_completion <= NumChannels'(1) << r_srv_chan;
            r_timeout    <= 1'b1;
            r_state      <= COMPLETE;
`endif
          end else if (srv_ack_i) begin
            r_irq   <= 1'b0;
            r_state <= SERVICE;
          end
        end
        SERVICE: begin
`ifdef SCMI_DOORBELL_SCHED_TIMEOUT_EN
          r_cnt <= r_cnt + CntW'(1);
`endif
          if (srv_done_i) begin
            r_completion <= NumChannels'(1) << r_srv_chan;
            r_state      <= COMPLETE;
`ifdef SCMI_DOORBELL_SCHED_TIMEOUT_EN
          end else if (w_limit) begin
            r_completion <= NumChannels'(1) << r_srv_chan;
            r_timeout    <= 1'b1;
            r_state      <= COMPLETE;
`endif
          end
        end
        COMPLETE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_irq   <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign srv_irq_o    = r_irq;
  assign srv_chan_o   = r_srv_chan;
  assign completion_o = r_completion;
  assign pending_o    = r_pending;
  assign busy_o       = r_busy;

endmodule

// File: tb/tb_scmi_doorbell_scheduler.sv
// Directed bench for scmi_doorbell_scheduler with four channels.
// Timeout checks are compiled only with SCMI_DOORBELL_SCHED_TIMEOUT_EN.
module tb_scmi_doorbell_scheduler;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic [3:0] doorbell_i = '0;
  logic [3:0] chan_en_i = 4'b1111;
  logic       srv_irq_o;
  logic [1:0] srv_chan_o;
  logic       srv_ack_i = 1'b0;
  logic       srv_done_i = 1'b0;
  logic [3:0] completion_o;
  logic [3:0] pending_o;
  logic       busy_o;
  logic       timeout_o;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  scmi_doorbell_scheduler #(.NumChannels(4), .TimeoutCycles(16)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .doorbell_i   (doorbell_i),
    .chan_en_i    (chan_en_i),
    .srv_irq_o    (srv_irq_o),
    .srv_chan_o   (srv_chan_o),
    .srv_ack_i    (srv_ack_i),
    .srv_done_i   (srv_done_i),
    .completion_o (completion_o),
    .pending_o    (pending_o),
    .busy_o       (busy_o),
    .timeout_o    (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_ni     = 1'b0;
    doorbell_i = '0;
    chan_en_i  = 4'b1111;
    srv_ack_i  = 1'b0;
    srv_done_i = 1'b0;
    tick();
    tick();
    rst_ni = 1'b1;
    cyc    = 0;
  endtask

  task automatic wait_irq(input string tag);
    int n;
    n = 0;
    while (srv_irq_o !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check({tag, " irq"}, {31'b0, srv_irq_o}, 32'd1);
  endtask

  // Serve the presented request: ack after 3 cycles, done 3 cycles later.
  task automatic serve(input logic [1:0] exp_ch, input string tag);
    wait_irq(tag);
    check({tag, " chan"}, {30'b0, srv_chan_o}, {30'b0, exp_ch});
    repeat (2) tick();
    srv_ack_i = 1'b1;
    tick();
    srv_ack_i = 1'b0;
    repeat (2) tick();
    srv_done_i = 1'b1;
    tick();
    srv_done_i = 1'b0;
    check({tag, " completion"}, {28'b0, completion_o}, 32'd1 << exp_ch);
    tick();
  endtask

  initial begin
    logic [3:0] seen;

    // Reset values
    #1;
    check("rst irq", {31'b0, srv_irq_o}, 0);
    check("rst busy", {31'b0, busy_o}, 0);
    check("rst pending", {28'b0, pending_o}, 0);
    check("rst completion", {28'b0, completion_o}, 0);
    check("rst chan", {30'b0, srv_chan_o}, 0);
    check("rst timeout", {31'b0, timeout_o}, 0);
    do_reset();

    // Single request on channel 2
    while (cyc < 10) tick();
    doorbell_i[2] = 1'b1;
    tick();
    check("single irq@11", {31'b0, srv_irq_o}, 0);
    check("single pending@11", {28'b0, pending_o}, 4'b0100);
    tick();
    check("single irq@12", {31'b0, srv_irq_o}, 1);
    check("single chan@12", {30'b0, srv_chan_o}, 2);
    check("single pending@12", {28'b0, pending_o}, 0);
    check("single busy@12", {31'b0, busy_o}, 1);
    while (cyc < 15) tick();
    srv_ack_i = 1'b1;
    tick();
    srv_ack_i = 1'b0;
    check("single irq after ack", {31'b0, srv_irq_o}, 0);
    check("single busy in service", {31'b0, busy_o}, 1);
    while (cyc < 20) tick();
    srv_done_i = 1'b1;
    tick();
    srv_done_i = 1'b0;
    check("single completion@21", {28'b0, completion_o}, 4'b0100);
    check("single busy@21", {31'b0, busy_o}, 1);
    tick();
    check("single completion@22", {28'b0, completion_o}, 0);
    check("single busy@22", {31'b0, busy_o}, 0);
    check("single chan held", {30'b0, srv_chan_o}, 2);

    // Fairness
    do_reset();
    tick();
    doorbell_i = 4'b1111;
    tick();
    check("fair pending all", {28'b0, pending_o}, 4'b1111);
    serve(2'd0, "fair g0");
    serve(2'd1, "fair g1");
    serve(2'd2, "fair g2");
    serve(2'd3, "fair g3");
    doorbell_i = '0;
    tick();
    tick();
    check("fair idle", {31'b0, busy_o}, 0);
    doorbell_i = 4'b1001;
    tick();
    serve(2'd0, "fair r0");
    serve(2'd3, "fair r3");
    doorbell_i = '0;

    // Masking, set/clear collision, combined ack/done
    do_reset();
    chan_en_i     = 4'b1101;
    doorbell_i[1] = 1'b1;
    tick();
    doorbell_i[1] = 1'b0;
    tick();
    tick();
    check("mask pending", {28'b0, pending_o}, 4'b0010);
    check("mask no grant", {31'b0, busy_o}, 0);
    chan_en_i     = 4'b1111;
    doorbell_i[1] = 1'b1;
    tick();
    check("collide irq", {31'b0, srv_irq_o}, 1);
    check("collide chan", {30'b0, srv_chan_o}, 1);
    check("collide pending kept", {28'b0, pending_o}, 4'b0010);
    srv_ack_i  = 1'b1;
    srv_done_i = 1'b1;
    tick();
    srv_ack_i  = 1'b0;
    srv_done_i = 1'b0;
    check("ackdone completion", {28'b0, completion_o}, 4'b0010);
    check("ackdone irq", {31'b0, srv_irq_o}, 0);
    tick();
    check("ackdone idle gap", {31'b0, busy_o}, 0);
    tick();
    check("regrant chan", {30'b0, srv_chan_o}, 1);
    check("regrant irq", {31'b0, srv_irq_o}, 1);
    chan_en_i[1] = 1'b0;
    srv_ack_i    = 1'b1;
    tick();
    srv_ack_i = 1'b0;
    tick();
    check("disable no abort", {31'b0, busy_o}, 1);
    srv_done_i = 1'b1;
    tick();
    srv_done_i = 1'b0;
    check("disable completion", {28'b0, completion_o}, 4'b0010);
    doorbell_i = '0;
    chan_en_i  = 4'b1111;
    repeat (3) tick();
    srv_done_i = 1'b1;
    tick();
    srv_done_i = 1'b0;
    check("stray done completion", {28'b0, completion_o}, 0);
    check("stray done busy", {31'b0, busy_o}, 0);
    srv_ack_i = 1'b1;
    tick();
    srv_ack_i = 1'b0;
    check("stray ack busy", {31'b0, busy_o}, 0);

    // Reset mid-service
    do_reset();
    doorbell_i[2] = 1'b1;
    tick();
    wait_irq("rstmid");
    srv_ack_i = 1'b1;
    tick();
    srv_ack_i = 1'b0;
    tick();
    rst_ni = 1'b0;
    #1;
    check("rstmid busy", {31'b0, busy_o}, 0);
    check("rstmid chan", {30'b0, srv_chan_o}, 0);
    check("rstmid pending", {28'b0, pending_o}, 0);
    doorbell_i = '0;
    tick();
    rst_ni = 1'b1;
    seen = '0;
    srv_done_i = 1'b1;
    tick();
    srv_done_i = 1'b0;
    seen |= completion_o;
    repeat (4) begin
      tick();
      seen |= completion_o;
    end
    check("rstmid no completion", {28'b0, seen}, 0);
    check("rstmid pending after", {28'b0, pending_o}, 0);
    check("rstmid idle after", {31'b0, busy_o}, 0);

`ifdef SCMI_DOORBELL_SCHED_TIMEOUT_EN
    // Watchdog: timeout with ack and no done
    do_reset();
    doorbell_i[3] = 1'b1;
    tick();
    wait_irq("to");
    srv_ack_i = 1'b1;
    tick();
    srv_ack_i = 1'b0;
    repeat (14) tick();
    check("to early completion", {28'b0, completion_o}, 0);
    check("to early timeout", {31'b0, timeout_o}, 0);
    tick();
    check("to completion", {28'b0, completion_o}, 4'b1000);
    check("to timeout", {31'b0, timeout_o}, 1);
    tick();
    check("to timeout pulse", {31'b0, timeout_o}, 0);
    doorbell_i = '0;
    tick();
    // Done on the limit cycle wins
    doorbell_i[0] = 1'b1;
    tick();
    wait_irq("tolim");
    srv_ack_i = 1'b1;
    tick();
    srv_ack_i = 1'b0;
    repeat (14) tick();
    srv_done_i = 1'b1;
    tick();
    srv_done_i = 1'b0;
    check("tolim completion", {28'b0, completion_o}, 4'b0001);
    check("tolim no timeout", {31'b0, timeout_o}, 0);
    doorbell_i = '0;
`else
    // Without the watchdog the scheduler waits for done indefinitely
    do_reset();
    doorbell_i[3] = 1'b1;
    tick();
    wait_irq("nowd");
    srv_ack_i = 1'b1;
    tick();
    srv_ack_i = 1'b0;
    seen = '0;
    repeat (40) begin
      tick();
      seen |= completion_o | {3'b0, timeout_o};
    end
    check("nowd still busy", {31'b0, busy_o}, 1);
    check("nowd no pulse", {28'b0, seen}, 0);
    srv_done_i = 1'b1;
    tick();
    srv_done_i = 1'b0;
    check("nowd completion", {28'b0, completion_o}, 4'b1000);
    check("nowd timeout", {31'b0, timeout_o}, 0);
    doorbell_i = '0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
